// File: rtl/uart_pkg.sv
// Purpose: shared types for the UART transmit arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    localparam int DBIT_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        BUSY,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Purpose: combinational round-robin pick; first set bit at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; found=0 when no request bit is set.
//
// Ports:
//   req   : request vector
//   ptr   : search start index
//   idx   : chosen index (0 when found=0)
//   found : any request present
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                idx   = IW'((int'(ptr) + k) % N);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Purpose: shares one UART transmitter among N_REQ byte requesters, round-robin, optional packet lock.
// Latency: valid in IDLE -> req_ready next cycle -> tx_start the cycle after; tx_done -> next tx_start >= 3 cycles.
// Backpressure: requesters hold req_valid until a one-hot req_ready pulse; a silent transmitter is aborted by a watchdog.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/data/last : per-requester byte offer, data of requester i at [i*DBIT +: DBIT]
//   req_ready           : one-hot accept pulse (LOAD state only)
//   tx_start/din/done   : direct connection to the transmitter
//   busy                : any state other than IDLE
//   grant_id            : current or most recent granted requester
//   err_timeout         : one-cycle pulse when the watchdog aborts a transfer
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DBIT       = DBIT_DEF,
    parameter int LOCK_PKT   = 1,
    parameter int TX_TIMEOUT = 200000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*DBIT-1:0]    req_data,
    input  logic [N_REQ-1:0]         req_last,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     tx_start,
    output logic [DBIT-1:0]          tx_din,
    input  logic                     tx_done,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     err_timeout
);

    localparam int GW = $clog2(N_REQ);
    localparam int TW = $clog2(TX_TIMEOUT);
    localparam logic [TW-1:0] T_LAST = TW'(TX_TIMEOUT - 1);

    arb_state_t      state, state_nx;
    logic [GW-1:0]   rr_ptr;
    logic [GW-1:0]   pick_idx;
    logic            pick_found;
    logic [TW-1:0]   timer;
    logic            last_q;
    logic            timeout_hit;
    logic            rel_grant;  // transfer ends, grant goes back to round-robin
    logic            wd_abort;   // the end was forced by the watchdog

    rr_pick #(.N(N_REQ), .IW(GW)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign timeout_hit = (timer == T_LAST);

    always_comb begin
        state_nx  = state;
        rel_grant = 1'b0;
        wd_abort  = 1'b0;
        req_ready = '0;
        tx_start  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (pick_found) state_nx = LOAD;
            end
            LOAD: begin
                req_ready[grant_id] = 1'b1;
                state_nx            = START;
            end
            START: begin
                tx_start = 1'b1;
                state_nx = BUSY;
            end
            BUSY: begin
                // done beats a coincident timeout
                if (tx_done) begin
                    if ((LOCK_PKT != 0) && !last_q) begin
                        state_nx = HOLD;
                    end else begin
                        state_nx  = IDLE;
                        rel_grant = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_nx  = IDLE;
                    rel_grant = 1'b1;
                    wd_abort  = 1'b1;
                end
            end
            HOLD: begin
                // only the lock owner may continue; everyone else waits
                if (req_valid[grant_id]) begin
                    state_nx = LOAD;
                end else if (timeout_hit) begin
                    state_nx  = IDLE;
                    rel_grant = 1'b1;
                    wd_abort  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_id    <= '0;
            tx_din      <= '0;
            last_q      <= 1'b0;
            timer       <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= state_nx;
            err_timeout <= wd_abort;
            if (state == IDLE && pick_found) begin
                grant_id <= pick_idx;
            end
            if (state == LOAD) begin
                tx_din <= req_data[grant_id*DBIT +: DBIT];
                last_q <= req_last[grant_id];
            end
            // Restart on every state change; we leave BUSY/HOLD at T_LAST so it never wraps.
            if (state_nx != state) begin
                timer <= '0;
            end else if (state == BUSY || state == HOLD) begin
                timer <= timer + 1'b1;
            end
            if (rel_grant) begin
                rr_ptr <= (grant_id == GW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int TO = 50;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            tx_start;
    logic [DB-1:0]   tx_din;
    logic            tx_done;
    logic            busy;
    logic [1:0]      grant_id;
    logic            err_timeout;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .DBIT(DB), .LOCK_PKT(1), .TX_TIMEOUT(TO)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_din      (tx_din),
        .tx_done     (tx_done),
        .busy        (busy),
        .grant_id    (grant_id),
        .err_timeout (err_timeout)
    );

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_done   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- table-driven cycle vectors ----------------
    typedef struct {
        int         rep;
        logic       rst;
        logic [3:0] vld;
        logic       done;
        logic [3:0] e_rdy;
        logic       e_start;
        logic       e_busy;
        logic [1:0] e_gnt;
        logic [7:0] e_din;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    // ---------------- transaction-level reference model ----------------
    // Each requester is a queue of {last, data}; the transmitter answers each
    // start after a chosen delay (0 means it never answers).
    logic [8:0] rq[N][$];
    int         dly_q[$];
    int         order[$];

    task automatic run_engine(input int budget);
        int own = -1, rr = 0, arb_at = 0, rdy_at = -1, start_at = -1;
        int done_at = -1, err_at = -1, who = 0, pend = -1, c = 0, w, k;
        logic [8:0] cur = '0;
        bit fin = 0;
        order.delete();
        while (!fin) begin
            if (pend >= 0) begin
                void'(rq[pend].pop_front());
                pend = -1;
            end
            for (int i = 0; i < N; i++) begin
                req_valid[i]         = (rq[i].size() > 0);
                req_data[i*DB +: DB] = (rq[i].size() > 0) ? rq[i][0][7:0] : 8'h00;
                req_last[i]          = (rq[i].size() > 0) ? rq[i][0][8] : 1'b0;
            end
            tx_done = (c == done_at);
            if (c == err_at) begin
                own    = -1;
                rr     = (who + 1) % N;
                arb_at = c;
            end
            if (c == arb_at) begin
                w = -1;
                if (own >= 0) begin
                    if (rq[own].size() > 0) w = own;
                end else begin
                    for (int j = 0; j < N; j++)
                        if (w < 0 && rq[(rr + j) % N].size() > 0) w = (rr + j) % N;
                end
                if (w >= 0) begin
                    who    = w;
                    rdy_at = c + 1;
                end else if (own < 0) begin
                    fin = 1;
                end
            end
            chk("eng ready", req_ready, (c == rdy_at) ? (1 << who) : 0);
            chk("eng start", tx_start, (c == start_at));
            chk("eng err", err_timeout, (c == err_at));
            if (c == err_at) chk("eng busy at err", busy, 0);
            if (c == rdy_at) begin
                cur      = rq[who][0];
                pend     = who;
                start_at = c + 1;
            end
            if (c == start_at) begin
                chk("eng din", tx_din, cur[7:0]);
                chk("eng grant", grant_id, who);
                order.push_back(who);
                if (dly_q.size() > 0) k = dly_q.pop_front();
                else if ($urandom_range(0, 9) == 0) k = 0;
                else if ($urandom_range(0, 3) == 0) k = TO;
                else k = $urandom_range(1, TO - 1);
                done_at = (k > 0) ? c + k : -1;
                err_at  = (k > 0) ? -1 : c + TO + 1;
            end
            if (c == done_at) begin
                if (!cur[8]) begin
                    own = who;
                    if (rq[who].size() > 0) arb_at = c + 1;
                    else err_at = c + TO + 1;
                end else begin
                    own    = -1;
                    rr     = (who + 1) % N;
                    arb_at = c + 1;
                end
            end
            if (c >= budget) begin
                n_chk++;
                n_err++;
                $display("FAIL engine budget: still active after %0d cycles, expected idle", c);
                fin = 1;
            end
            tick();
            c++;
        end
        tx_done = 1'b0;
        dly_q.delete();
    endtask

    task automatic check_order(input string nm, input int exp[$]);
        chk({nm, " count"}, order.size(), exp.size());
        for (int i = 0; i < exp.size() && i < order.size(); i++)
            chk({nm, " grant"}, order[i], exp[i]);
    endtask

    initial begin
        int e[$];
        int npk, len;
        logic lst;

        // ---- directed table: single byte, round-robin pointer, ignored done, reset mid-BUSY ----
        tbl.push_back('{1, 0, 4'b0001, 0, 4'b0000, 0, 0, 2'd0, 8'h00, 0});
        tbl.push_back('{1, 0, 4'b0001, 0, 4'b0001, 0, 1, 2'd0, 8'h00, 0});
        tbl.push_back('{1, 0, 4'b0000, 0, 4'b0000, 1, 1, 2'd0, 8'hA5, 0});
        tbl.push_back('{9, 0, 4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'hA5, 0});
        tbl.push_back('{1, 0, 4'b0000, 1, 4'b0000, 0, 1, 2'd0, 8'hA5, 0});
        tbl.push_back('{1, 0, 4'b0011, 1, 4'b0000, 0, 0, 2'd0, 8'hA5, 0});
        tbl.push_back('{1, 0, 4'b0011, 1, 4'b0010, 0, 1, 2'd1, 8'hA5, 0});
        tbl.push_back('{1, 0, 4'b0001, 0, 4'b0000, 1, 1, 2'd1, 8'h22, 0});
        tbl.push_back('{2, 0, 4'b0001, 0, 4'b0000, 0, 1, 2'd1, 8'h22, 0});
        tbl.push_back('{1, 0, 4'b0001, 1, 4'b0000, 0, 1, 2'd1, 8'h22, 0});
        tbl.push_back('{1, 0, 4'b0001, 0, 4'b0000, 0, 0, 2'd1, 8'h22, 0});
        tbl.push_back('{1, 0, 4'b0001, 0, 4'b0001, 0, 1, 2'd0, 8'h22, 0});
        tbl.push_back('{1, 0, 4'b0000, 0, 4'b0000, 1, 1, 2'd0, 8'hA5, 0});
        tbl.push_back('{1, 1, 4'b0000, 0, 4'b0000, 0, 1, 2'd0, 8'hA5, 0});
        tbl.push_back('{1, 0, 4'b1001, 0, 4'b0000, 0, 0, 2'd0, 8'h00, 0});
        tbl.push_back('{1, 0, 4'b1001, 0, 4'b0001, 0, 1, 2'd0, 8'h00, 0});

        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
        req_last = 4'hF;
        foreach (tbl[r]) begin
            for (int k = 0; k < tbl[r].rep; k++) begin
                reset     = tbl[r].rst;
                req_valid = tbl[r].vld;
                tx_done   = tbl[r].done;
                chk($sformatf("tbl%0d ready", r), req_ready, tbl[r].e_rdy);
                chk($sformatf("tbl%0d start", r), tx_start, tbl[r].e_start);
                chk($sformatf("tbl%0d busy", r), busy, tbl[r].e_busy);
                chk($sformatf("tbl%0d grant", r), grant_id, tbl[r].e_gnt);
                chk($sformatf("tbl%0d din", r), tx_din, tbl[r].e_din);
                chk($sformatf("tbl%0d err", r), err_timeout, tbl[r].e_err);
                tick();
            end
        end
        reset = 1'b0;

        // ---- all four valid, single-byte packets: grants wrap 0..3,0..3 ----
        do_reset();
        for (int i = 0; i < N; i++) begin
            rq[i].push_back({1'b1, 8'(8'h10 + i)});
            rq[i].push_back({1'b1, 8'(8'h20 + i)});
        end
        dly_q = '{3, 3, 3, 3, 3, 3, 3, 3};
        run_engine(2000);
        e = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_order("rr wrap", e);

        // ---- packet lock: req1 three bytes, req2 waits throughout ----
        do_reset();
        rq[1].push_back({1'b0, 8'hB1});
        rq[1].push_back({1'b0, 8'hB2});
        rq[1].push_back({1'b1, 8'hB3});
        rq[2].push_back({1'b1, 8'hC1});
        dly_q = '{4, 4, 4, 4};
        run_engine(2000);
        e = '{1, 1, 1, 2};
        check_order("lock", e);

        // ---- silent transmitter: watchdog abort, next requester served ----
        do_reset();
        rq[0].push_back({1'b1, 8'h11});
        rq[1].push_back({1'b1, 8'h22});
        dly_q = '{0, 5};
        run_engine(2000);
        e = '{0, 1};
        check_order("timeout", e);

        // ---- done on the last watchdog cycle: no error ----
        do_reset();
        rq[0].push_back({1'b1, 8'h5A});
        dly_q = '{TO};
        run_engine(2000);
        e = '{0};
        check_order("done at limit", e);

        // ---- owner stalls mid-packet: HOLD watchdog, others ignored until abort ----
        do_reset();
        rq[0].push_back({1'b0, 8'h77});
        rq[2].push_back({1'b1, 8'h99});
        dly_q = '{3, 3};
        run_engine(2000);
        e = '{0, 2};
        check_order("hold timeout", e);

        // ---- randomized packets against the model ----
        for (int round = 0; round < 3; round++) begin
            do_reset();
            for (int i = 0; i < N; i++) begin
                npk = $urandom_range(0, 3);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        lst = (b == len - 1);
                        if (p == npk - 1 && lst && $urandom_range(0, 3) == 0) lst = 1'b0;
                        rq[i].push_back({lst, 8'($urandom_range(0, 255))});
                    end
                end
            end
            run_engine(20000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

endmodule
